lap_record_queue: RTL

- Buffers lap timestamps between the key FSM/timer and the LCD bridge.
- Packed BCD lap records are pushed on each lap event and held in a small FIFO.
- Records are handed one at a time to the LCD bridge through its insert/busy handshake, so laps taken while the LCD is busy are not lost.
- Sits between the key logic FSM insert pulse / flattened BCD timestamp and the lcd_bridge insert/new_record/busy inputs.

---
 rtl/lap_record_queue_if.sv | 35 +++
 rtl/lap_record_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lap_record_queue_if.sv
// ---------------------------------------------------------------------------
// lap_record_queue_if
//   Bundles the lap-record producer side (push/record_in/clear), the LCD
//   bridge handshake (insert_out/record_out/lcd_busy) and the queue status
//   outputs of lap_record_queue.
//
//   master : drives push, record_in, clear, lcd_busy; observes the rest
//   slave  : the queue itself (lap_record_queue)
// ---------------------------------------------------------------------------
interface lap_record_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] record_in;
    logic                  clear;
    logic                  lcd_busy;
    logic                  insert_out;
    logic [DATA_WIDTH-1:0] record_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic [7:0]            dropped;

    modport master (
        output push, record_in, clear, lcd_busy,
        input  insert_out, record_out, count, empty, full, overflow, dropped
    );

    modport slave (
        input  push, record_in, clear, lcd_busy,
        output insert_out, record_out, count, empty, full, overflow, dropped
    );
endinterface

// File: rtl/lap_record_queue.sv
// ---------------------------------------------------------------------------
// lap_record_queue
//   Small FIFO of packed BCD lap records sitting between the key FSM / timer
//   and the LCD bridge. Each record is handed to the bridge with a one-cycle
//   insert strobe, then the queue waits for the bridge busy flag to rise and
//   fall (or for a rise timeout) before offering the next record.
//
//   Ports:
//     clock    : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : lap_record_queue_if.slave
//                  push/record_in  - one-cycle record capture strobe
//                  clear           - synchronous flush of contents/status
//                  lcd_busy        - busy flag from the LCD bridge
//                  insert_out      - one-cycle insert strobe to the bridge
//                  record_out      - record presented with insert_out
//                  count/empty/full- occupancy
//                  overflow        - sticky: a push was dropped
//                  dropped         - saturating dropped-push counter
// ---------------------------------------------------------------------------
module lap_record_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    lap_record_queue_if.slave   bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic [7:0]            dropped_q;
    logic                  insert_q;
    logic [DATA_WIDTH-1:0] record_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic full_w;
    logic pop;
    logic push_ok;
    logic push_drop;

    assign full_w = (count_q == CW'(DEPTH));

    // A clear in IDLE suppresses the pop: the queue is being flushed.
    assign pop       = (state == IDLE) && (count_q != '0) && !bus.lcd_busy && !bus.clear;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign push_ok   = bus.push && !bus.clear && (!full_w || pop);
    assign push_drop = bus.push && !bus.clear && full_w && !pop;

    // NOTE: the storage array has no reset; only pointers/count define validity,
    // so resetting it would just add reset fan-out for no functional benefit.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.record_in;
        end
    end

    // Pointers, occupancy and drop status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else if (bus.clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != 8'hFF) begin
                    dropped_q <= dropped_q + 8'd1;
                end
            end
        end
    end

    // Handshake FSM with registered insert strobe and record.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            insert_q <= 1'b0;
            record_q <= '0;
        end else begin
            // NOTE: default low each cycle so the strobe is exactly one cycle
            // wide without a separate clearing branch in every state.
            insert_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        record_q <= mem[rd_ptr];
                        insert_q <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The pulse of this cycle stands; a clear only skips the wait.
                    if (bus.clear) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_HI;
                        timer <= TW'(BUSY_WAIT);
                    end
                end
                WAIT_HI: begin
                    if (bus.lcd_busy) begin
                        state <= WAIT_LO;
                    end else if (timer <= TW'(1)) begin
                        // Bridge never signalled busy: treat insert as accepted.
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!bus.lcd_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.insert_out = insert_q;
    assign bus.record_out = record_q;
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = full_w;
    assign bus.overflow   = overflow_q;
    assign bus.dropped    = dropped_q;
endmodule
